async_dualram_16x8: RTL and testbench
=====================================

# async_dualram_16x8

Simple dual-port 16-word × 8-bit RAM with one write port and one read port, both synchronous to a single clock. The write and read ports operate independently and may be active in the same cycle. A chip select gates both ports. It is a general-purpose storage primitive for small register files and buffers.

## Interface
Parameters:
- ADDR_WIDTH, 4: address width of both ports.
- DEPTH, 16: number of words; must equal 2**ADDR_WIDTH.
- DATA_WIDTH, 8: word width.

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- cs  input  1  chip select; active high; gates both ports.
- wr_enb  input  1  write enable, active high.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_enb  input  1  read enable, active high.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  registered read data.

## Operation
- Storage: DEPTH × DATA_WIDTH array; addresses 0..DEPTH-1; full address range valid, no wrap logic needed.
- Priority per rising edge: reset > cs gating > port operations.
- Reset (rst=0 at edge): every memory word cleared to 0, rd_data cleared to 0; wr_enb/rd_enb ignored that edge.
- cs=0 (rst=1): no write, no read; memory and rd_data hold.
- Write (rst=1, cs=1, wr_enb=1): mem[wr_addr] <= wr_data.
- Read (rst=1, cs=1, rd_enb=1): rd_data <= mem[rd_addr].
- rd_enb=0 (or cs=0): rd_data holds its last value.
- Simultaneous read and write, different addresses: both complete; read returns the old contents of rd_addr.
- Simultaneous read and write, same address: write-first; rd_data gets the new wr_data, and memory is updated.
- wr_enb=0: wr_addr/wr_data are don't-care; memory unchanged.
- No X is ever driven on rd_data after the first reset.

## Timing
- Write latency: data stored at the enabling edge; visible to a read issued at the same edge (bypass) or any later edge.
- Read latency: 1 cycle; rd_data valid after the edge where cs&rd_enb are sampled high.
- Reset takes effect at the first rising edge with rst=0; rd_data=0 from that edge onward.
- Reset asserted mid-operation: any write or read in that cycle is discarded; the memory is fully cleared.
- Throughput: one write and one read per cycle, sustained.
- Inputs sampled only at the rising edge; asynchronous changes between edges have no effect.

## Test plan
- Reset: write 0xA5 to addr 3, then hold rst=0 for one edge; read addr 3 -> rd_data=0x00, and rd_data=0x00 immediately after the reset edge.
- Write/read back: write 0x11,0x22,0x33,0x44,0x55 to addrs 0,5,9,12,15 (cs=1); read the same addrs -> rd_data equals each value one cycle after the read edge; rd_data holds once rd_enb drops.
- Chip select: with cs=0, write 0xFF to addr 5 and read addr 5 -> memory still 0x22, rd_data unchanged; with cs=1, read addr 5 -> 0x22.
- Simultaneous, different addresses: write 0x77 to addr 2 while reading addr 9 (0x33) -> rd_data=0x33; next read of addr 2 -> 0x77.
- Collision: write 0xC3 to addr 12 while reading addr 12 in the same cycle -> rd_data=0xC3 (write-first); a later read -> 0xC3.
- Randomized: 6 cycles of random simultaneous writes/reads checked against a reference model, including addr 0 and addr 15 boundaries.

Source files
------------

// File: rtl/async_dualram_16x8.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Synchronous active-low reset clears every word and the read register.
module async_dualram_16x8 #(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  wr_enb,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_enb,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic                  wr_go;
    logic                  rd_go;
    logic                  bypass;

    assign wr_go  = cs && wr_enb;
    assign rd_go  = cs && rd_enb;
    assign bypass = wr_go && (wr_addr == rd_addr);

    always_comb begin
        mem_d     = mem_q;
        rd_data_d = rd_data_q;
        if (wr_go) begin
            mem_d[wr_addr] = wr_data;
        end
        // Same-address collision returns the word being written.
        if (rd_go) begin
            rd_data_d = bypass ? wr_data : mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_async_dualram_16x8.sv
// Directed and short randomized checks for the 16x8 simple dual-port RAM.
module tb_async_dualram_16x8;

    logic       clk;
    logic       rst;
    logic       cs;
    logic       wr_enb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_enb;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;

    int n_cmp;
    int n_err;
    logic [7:0] model [16];

    async_dualram_16x8 dut (
        .clk    (clk),
        .rst    (rst),
        .cs     (cs),
        .wr_enb (wr_enb),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_enb (rd_enb),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive, take the edge, settle; keeps the write model in step.
    task automatic step(input logic c, input logic we, input logic [3:0] wa,
                        input logic [7:0] wd, input logic re, input logic [3:0] ra);
        cs = c; wr_enb = we; wr_addr = wa; wr_data = wd;
        rd_enb = re; rd_addr = ra;
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < 16; i++) model[i] = 8'h00;
        end else if (c && we) begin
            model[wa] = wd;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_initial: got %h expected 00", rd_data);
        end
        rst = 1'b1;
        step(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, 4'd3);
        n_cmp++;
        if (rd_data !== 8'hA5) begin
            n_err++;
            $display("FAIL reset_prewrite: got %h expected a5", rd_data);
        end
        rst = 1'b0;
        step(1'b1, 1'b1, 4'd7, 8'h5A, 1'b1, 4'd3);
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_edge: got %h expected 00", rd_data);
        end
        rst = 1'b1;
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_cleared_a3: got %h expected 00", rd_data);
        end
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_discard_wr: got %h expected 00", rd_data);
        end
    endtask

    task automatic test_write_read;
        logic [3:0] a [5];
        logic [7:0] d [5];
        a = '{4'd0, 4'd5, 4'd9, 4'd12, 4'd15};
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, a[i], d[i], 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, a[i]);
            n_cmp++;
            if (rd_data !== d[i]) begin
                n_err++;
                $display("FAIL readback_%0d: got %h expected %h", a[i], rd_data, d[i]);
            end
        end
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd5);
        n_cmp++;
        if (rd_data !== 8'h55) begin
            n_err++;
            $display("FAIL read_hold: got %h expected 55", rd_data);
        end
    endtask

    task automatic test_cs;
        step(1'b0, 1'b1, 4'd5, 8'hFF, 1'b1, 4'd5);
        n_cmp++;
        if (rd_data !== 8'h55) begin
            n_err++;
            $display("FAIL cs_hold: got %h expected 55", rd_data);
        end
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
        n_cmp++;
        if (rd_data !== 8'h22) begin
            n_err++;
            $display("FAIL cs_nowrite: got %h expected 22", rd_data);
        end
    endtask

    task automatic test_simul;
        step(1'b1, 1'b1, 4'd2, 8'h77, 1'b1, 4'd9);
        n_cmp++;
        if (rd_data !== 8'h33) begin
            n_err++;
            $display("FAIL simul_old: got %h expected 33", rd_data);
        end
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2);
        n_cmp++;
        if (rd_data !== 8'h77) begin
            n_err++;
            $display("FAIL simul_new: got %h expected 77", rd_data);
        end
    endtask

    task automatic test_collision;
        step(1'b1, 1'b1, 4'd12, 8'hC3, 1'b1, 4'd12);
        n_cmp++;
        if (rd_data !== 8'hC3) begin
            n_err++;
            $display("FAIL collide_bypass: got %h expected c3", rd_data);
        end
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd0);
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd12);
        n_cmp++;
        if (rd_data !== 8'hC3) begin
            n_err++;
            $display("FAIL collide_stored: got %h expected c3", rd_data);
        end
    endtask

    task automatic test_random;
        logic       we;
        logic [3:0] wa;
        logic [3:0] ra;
        logic [7:0] wd;
        logic [7:0] exp;
        for (int i = 0; i < 6; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            wd = 8'($urandom_range(0, 255));
            if (i == 0) begin we = 1'b1; wa = 4'd0;  ra = 4'd0;  end
            if (i == 1) begin we = 1'b1; wa = 4'd15; ra = 4'd0;  end
            if (i == 2) begin            ra = 4'd15;             end
            exp = (we && wa == ra) ? wd : model[ra];
            step(1'b1, we, wa, wd, 1'b1, ra);
            n_cmp++;
            if (rd_data !== exp) begin
                n_err++;
                $display("FAIL random_%0d: addr %0d got %h expected %h", i, ra, rd_data, exp);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0; cs = 1'b0; wr_enb = 1'b0; rd_enb = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        test_reset;
        test_write_read;
        test_cs;
        test_simul;
        test_collision;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
